// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
//   Interrupt controller for the timer peripheral and other event sources.
//   Event lines are latched as pending (rising-edge or level per source), gated
//   by a per-source enable, and arbitrated with fixed priority (source 0 is
//   highest). A single CPU request is raised with an ack / end-of-interrupt
//   handshake. The register file sits on the peripheral bus.
//
//   Optional build macro: IRQ_SYNC_EN
//     defined   : each i_IrqSrc bit passes a 2-flop synchronizer before detection
//                 (edge to o_Irq latency 4 cycles)
//     undefined : sources are synchronous to i_Clk (edge to o_Irq latency 2)
//
// Ports
//   i_Clk, i_Rst        clock, asynchronous active-high reset
//   i_WEnable/WAddr/WData  bus write (index addressing)
//   i_REnable/RAddr     bus read request; o_RData valid the next cycle
//   o_RData, o_Err      registered read data and bus error
//   i_IrqSrc            event lines (bit 0 timer overflow, bit 1 timer one-pulse)
//   o_Irq, o_IrqId      registered interrupt request and requesting source ID
//   i_IrqAck            CPU acknowledge pulse
//
// Register map: 0 ENABLE, 1 PENDING (W1C), 2 EDGE, 3 STATUS (RO),
//               4 EOI (WO), 5 SWSET (WO, write-1-to-set)
// -----------------------------------------------------------------------------
module irq_controller #(
    parameter int N_SRC = 8,
    parameter int ID_W  = 4
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_WEnable,
    input  logic [31:0]       i_WAddr,
    input  logic [31:0]       i_WData,
    input  logic              i_REnable,
    input  logic [31:0]       i_RAddr,
    output logic [31:0]       o_RData,
    output logic              o_Err,
    input  logic [N_SRC-1:0]  i_IrqSrc,
    output logic              o_Irq,
    output logic [ID_W-1:0]   o_IrqId,
    input  logic              i_IrqAck
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t            state_r;
    logic [ID_W-1:0]   id_r;
    logic [N_SRC-1:0]  enable_r;
    logic [N_SRC-1:0]  edge_r;
    logic [N_SRC-1:0]  pending_r;
    logic [N_SRC-1:0]  src_prev_r;

    logic [N_SRC-1:0]  src_s;
    logic [N_SRC-1:0]  det_s;
    logic [N_SRC-1:0]  cand_s;
    logic [N_SRC-1:0]  id_oh_s;
    logic [N_SRC-1:0]  ack_clr_s;
    logic [N_SRC-1:0]  w1c_s;
    logic [N_SRC-1:0]  swset_s;
    logic [N_SRC-1:0]  enable_nxt_s;
    logic [N_SRC-1:0]  edge_nxt_s;
    logic [N_SRC-1:0]  pending_nxt_s;
    logic              eoi_s;
    logic              wr_err_s;
    logic              rd_err_s;
    logic [31:0]       rdata_s;
    logic [ID_W-1:0]   win_id_s;
    logic              win_vld_s;
    logic              unused_s;

    // Data bits above the source count carry no meaning in any register.
    assign unused_s = ^i_WData[31:N_SRC];

`ifdef IRQ_SYNC_EN
    logic [N_SRC-1:0] sync1_r;
    logic [N_SRC-1:0] sync2_r;

    // Two-flop synchronizer for asynchronous event lines.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= i_IrqSrc;
            sync2_r <= sync1_r;
        end
    end
    assign src_s = sync2_r;
`else
    assign src_s = i_IrqSrc;
`endif

    // Edge sources fire on 0->1, level sources on every high cycle.
    assign det_s  = src_s & ((~src_prev_r & edge_r) | ~edge_r);
    assign cand_s = pending_r & enable_r;

    // Bus write decode: register updates, W1C/W1S masks, EOI and error flags.
    always_comb begin
        enable_nxt_s = enable_r;
        edge_nxt_s   = edge_r;
        w1c_s        = '0;
        swset_s      = '0;
        eoi_s        = 1'b0;
        wr_err_s     = 1'b0;
        if (i_WEnable) begin
            case (i_WAddr)
                32'd0:   enable_nxt_s = i_WData[N_SRC-1:0];
                32'd1:   w1c_s        = i_WData[N_SRC-1:0];
                32'd2:   edge_nxt_s   = i_WData[N_SRC-1:0];
                32'd3:   wr_err_s     = 1'b1;
                32'd4:   eoi_s        = 1'b1;
                32'd5:   swset_s      = i_WData[N_SRC-1:0];
                default: wr_err_s     = 1'b1;
            endcase
        end else begin
            eoi_s = 1'b0;
        end
    end

    // One-hot of the latched ID and the acknowledge clear (edge sources only).
    always_comb begin
        id_oh_s   = '0;
        ack_clr_s = '0;
        for (int i = 0; i < N_SRC; i++) begin
            id_oh_s[i] = (id_r == ID_W'(i));
        end
        if ((state_r == ST_ASSERT) && i_IrqAck) begin
            ack_clr_s = id_oh_s & edge_r;
        end else begin
            ack_clr_s = '0;
        end
    end

    // New events and software set override any clear in the same cycle.
    assign pending_nxt_s = (pending_r & ~(w1c_s | ack_clr_s)) | det_s | swset_s;

    // Fixed priority: lowest index wins, so scan from the top down.
    always_comb begin
        win_id_s  = '0;
        win_vld_s = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (cand_s[i]) begin
                win_id_s  = ID_W'(i);
                win_vld_s = 1'b1;
            end else begin
                win_id_s  = win_id_s;
                win_vld_s = win_vld_s;
            end
        end
    end

    // Read mux; indices 4 and 5 are write-only and read as zero.
    always_comb begin
        rdata_s  = 32'd0;
        rd_err_s = 1'b0;
        case (i_RAddr)
            32'd0:   rdata_s[N_SRC-1:0] = enable_r;
            32'd1:   rdata_s[N_SRC-1:0] = pending_r;
            32'd2:   rdata_s[N_SRC-1:0] = edge_r;
            32'd3: begin
                rdata_s[9:8]      = state_r;
                rdata_s[ID_W-1:0] = id_r;
            end
            32'd4:   rdata_s  = 32'd0;
            32'd5:   rdata_s  = 32'd0;
            default: rd_err_s = 1'b1;
        endcase
    end

    // Configuration, pending and source-history registers.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            enable_r   <= '0;
            edge_r     <= '0;
            pending_r  <= '0;
            src_prev_r <= '0;
        end else begin
            enable_r   <= enable_nxt_s;
            edge_r     <= edge_nxt_s;
            pending_r  <= pending_nxt_s;
            src_prev_r <= src_s;
        end
    end

    // Bus response: a write wins over a simultaneous read; idle cycles hold.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_RData <= 32'd0;
            o_Err   <= 1'b0;
        end else if (i_WEnable) begin
            o_Err <= wr_err_s;
        end else if (i_REnable) begin
            o_Err <= rd_err_s;
            if (!rd_err_s) begin
                o_RData <= rdata_s;
            end
        end
    end

    // Request FSM. A request is withdrawn when software clears the latched
    // source's enable or pending bit, judged on the values being written now.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_r <= ST_IDLE;
            id_r    <= '0;
            o_Irq   <= 1'b0;
            o_IrqId <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_vld_s) begin
                        state_r <= ST_ASSERT;
                        id_r    <= win_id_s;
                        o_Irq   <= 1'b1;
                        o_IrqId <= win_id_s;
                    end
                end
                ST_ASSERT: begin
                    if (i_IrqAck) begin
                        state_r <= ST_SERVICE;
                        o_Irq   <= 1'b0;
                    end else if (!(|(enable_nxt_s & pending_nxt_s & id_oh_s))) begin
                        state_r <= ST_IDLE;
                        o_Irq   <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    o_Irq <= 1'b0;
                    if (eoi_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    o_Irq   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// -----------------------------------------------------------------------------
// tb_irq_controller
//   Directed self-checking bench for irq_controller (default build).
//   Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_irq_controller;

    logic        i_Clk;
    logic        i_Rst;
    logic        i_WEnable;
    logic [31:0] i_WAddr;
    logic [31:0] i_WData;
    logic        i_REnable;
    logic [31:0] i_RAddr;
    logic [31:0] o_RData;
    logic        o_Err;
    logic [7:0]  i_IrqSrc;
    logic        o_Irq;
    logic [3:0]  o_IrqId;
    logic        i_IrqAck;

    int checks;
    int errors;

    logic [31:0] rd;
    logic        er;

    irq_controller #(.N_SRC(8), .ID_W(4)) dut (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_WEnable (i_WEnable),
        .i_WAddr   (i_WAddr),
        .i_WData   (i_WData),
        .i_REnable (i_REnable),
        .i_RAddr   (i_RAddr),
        .o_RData   (o_RData),
        .o_Err     (o_Err),
        .i_IrqSrc  (i_IrqSrc),
        .o_Irq     (o_Irq),
        .o_IrqId   (o_IrqId),
        .i_IrqAck  (i_IrqAck)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        i_WEnable = 1'b1;
        i_WAddr   = addr;
        i_WData   = data;
        tick();
        i_WEnable = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic err);
        i_REnable = 1'b1;
        i_RAddr   = addr;
        tick();
        i_REnable = 1'b0;
        data = o_RData;
        err  = o_Err;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        i_Rst     = 1'b1;
        i_WEnable = 1'b0;
        i_WAddr   = 32'd0;
        i_WData   = 32'd0;
        i_REnable = 1'b0;
        i_RAddr   = 32'd0;
        i_IrqSrc  = 8'h00;
        i_IrqAck  = 1'b0;
        tick();
        tick();
        chk("rst_irq",   {31'd0, o_Irq},   32'd0);
        chk("rst_id",    {28'd0, o_IrqId}, 32'd0);
        chk("rst_rdata", o_RData,          32'd0);
        chk("rst_err",   {31'd0, o_Err},   32'd0);
        i_Rst = 1'b0;
        tick();

        // All valid indices read zero without error; index 6 errors.
        for (int a = 0; a < 6; a++) begin
            bus_read(32'(a), rd, er);
            chk("rst_read_data", rd, 32'd0);
            chk("rst_read_err",  {31'd0, er}, 32'd0);
        end
        bus_read(32'd6, rd, er);
        chk("read6_err", {31'd0, er}, 32'd1);
        bus_write(32'd3, 32'd1);
        chk("write3_err", {31'd0, o_Err}, 32'd1);

        // Single edge source 0.
        bus_write(32'd0, 32'h01);
        bus_write(32'd2, 32'h01);
        chk("cfg_write_err", {31'd0, o_Err}, 32'd0);
        i_IrqSrc = 8'h01;
        tick();
        i_IrqSrc = 8'h00;
        chk("s0_lat1_irq", {31'd0, o_Irq}, 32'd0);
        tick();
        chk("s0_irq", {31'd0, o_Irq}, 32'd1);
        chk("s0_id",  {28'd0, o_IrqId}, 32'd0);
        bus_read(32'd3, rd, er);
        chk("s0_status_assert", rd, 32'h100);
        i_IrqAck = 1'b1;
        tick();
        i_IrqAck = 1'b0;
        chk("s0_ack_irq", {31'd0, o_Irq}, 32'd0);
        bus_read(32'd1, rd, er);
        chk("s0_pending", rd, 32'h00);
        bus_read(32'd3, rd, er);
        chk("s0_status_service", rd, 32'h200);
        bus_write(32'd4, 32'd0);
        bus_read(32'd3, rd, er);
        chk("s0_status_idle", rd, 32'h000);
        bus_read(32'd4, rd, er);
        chk("eoi_read_err", {31'd0, er}, 32'd0);

        // Sources 1 and 2 together: 1 wins, then 2 after EOI.
        bus_write(32'd0, 32'h06);
        bus_write(32'd2, 32'h06);
        i_IrqSrc = 8'h06;
        tick();
        i_IrqSrc = 8'h00;
        tick();
        chk("p12_irq", {31'd0, o_Irq}, 32'd1);
        chk("p12_id1", {28'd0, o_IrqId}, 32'd1);
        i_IrqAck = 1'b1;
        tick();
        i_IrqAck = 1'b0;
        bus_read(32'd1, rd, er);
        chk("p12_pending_after_ack", rd, 32'h04);
        bus_write(32'd4, 32'd0);
        tick();
        chk("p12_irq2", {31'd0, o_Irq}, 32'd1);
        chk("p12_id2",  {28'd0, o_IrqId}, 32'd2);
        i_IrqAck = 1'b1;
        tick();
        i_IrqAck = 1'b0;
        bus_write(32'd4, 32'd0);
        tick();
        chk("p12_done_irq", {31'd0, o_Irq}, 32'd0);

        // Level source 3 held high re-pends after EOI.
        bus_write(32'd2, 32'h00);
        bus_write(32'd0, 32'h08);
        i_IrqSrc = 8'h08;
        tick();
        tick();
        chk("lvl_irq", {31'd0, o_Irq}, 32'd1);
        chk("lvl_id",  {28'd0, o_IrqId}, 32'd3);
        i_IrqAck = 1'b1;
        tick();
        i_IrqAck = 1'b0;
        chk("lvl_ack_irq", {31'd0, o_Irq}, 32'd0);
        bus_read(32'd1, rd, er);
        chk("lvl_pending_kept", rd, 32'h08);
        bus_write(32'd4, 32'd0);
        chk("lvl_eoi_irq", {31'd0, o_Irq}, 32'd0);
        tick();
        chk("lvl_reassert_irq", {31'd0, o_Irq}, 32'd1);
        chk("lvl_reassert_id",  {28'd0, o_IrqId}, 32'd3);
        i_IrqSrc = 8'h00;
        i_IrqAck = 1'b1;
        tick();
        i_IrqAck = 1'b0;
        bus_write(32'd1, 32'h08);
        bus_write(32'd4, 32'd0);
        tick();
        chk("lvl_clean_irq", {31'd0, o_Irq}, 32'd0);
        bus_read(32'd1, rd, er);
        chk("lvl_clean_pending", rd, 32'h00);

        // Withdrawn request when ENABLE is cleared during ASSERT.
        bus_write(32'd2, 32'h01);
        bus_write(32'd0, 32'h01);
        i_IrqSrc = 8'h01;
        tick();
        i_IrqSrc = 8'h00;
        tick();
        chk("wd_irq", {31'd0, o_Irq}, 32'd1);
        bus_write(32'd0, 32'h00);
        tick();
        chk("wd_irq_dropped", {31'd0, o_Irq}, 32'd0);
        bus_read(32'd3, rd, er);
        chk("wd_status_idle", rd, 32'h000);
        bus_read(32'd1, rd, er);
        chk("wd_pending_kept", rd, 32'h01);

        // Edge set beats W1C in the same cycle.
        bus_write(32'd1, 32'h01);
        bus_read(32'd1, rd, er);
        chk("w1c_cleared", rd, 32'h00);
        i_IrqSrc = 8'h01;
        bus_write(32'd1, 32'h01);
        i_IrqSrc = 8'h00;
        bus_read(32'd1, rd, er);
        chk("set_wins", rd, 32'h01);

        // Reset asserted mid-ASSERT drops o_Irq without a clock edge.
        bus_write(32'd0, 32'h01);
        tick();
        chk("rst_mid_irq_before", {31'd0, o_Irq}, 32'd1);
        i_Rst = 1'b1;
        #1;
        chk("rst_mid_irq_after", {31'd0, o_Irq}, 32'd0);
        tick();
        i_Rst = 1'b0;
        tick();
        bus_read(32'd1, rd, er);
        chk("rst_mid_pending", rd, 32'h00);
        bus_read(32'd0, rd, er);
        chk("rst_mid_enable", rd, 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
